pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Fetch stage directly upstream of the branch unit.
- Holds the program counter and drives the instruction-memory address.
- Captures the fetched instruction into the IF/ID pipeline register.
- Consumes the branch unit's redirect (PCSel/BrPC) and the JALR redirect from EX to steer the next PC and squash wrong-path fetches.

Parameters:
- PC_W, 9: program-counter width in bits; instruction memory is byte-addressed, 2^PC_W bytes.
- INS_W, 32: instruction width.
- CNT_W, 8: width of the saturating redirect counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hazard stall from decode; hold PC and IF/ID.
- PCSel  in  1  branch taken (from branch unit).
- BrPC  in  32  branch target (from branch unit).
- JalrSel  in  1  JALR redirect from EX.
- JalrPC  in  32  JALR target, before LSB clearing.
- Instr  in  INS_W  instruction-memory read data for address PC; combinational, same cycle.
- PC  out  PC_W  current fetch address to instruction memory.
- IfId_PC  out  PC_W  PC of the instruction held in IF/ID.
- IfId_Instr  out  INS_W  instruction held in IF/ID.
- IfId_Valid  out  1  IF/ID holds a real instruction.
- Flush  out  1  combinational; a redirect is accepted this cycle.
- MisalignErr  out  1  sticky; a redirect target was not 4-byte aligned.
- RedirectCnt  out  CNT_W  saturating count of accepted redirects.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=0, IfId_PC=0, IfId_Instr=0x00000013 (NOP), IfId_Valid=0, MisalignErr=0, RedirectCnt=0, state=BOOT.
  - Reset asserted mid-operation overrides everything immediately.
- FSM states: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one cycle after reset deassertion.
  - PC held at 0, IfId_Valid=0, Flush=0; redirect inputs ignored.
  - Next state: RUN.
- RUN, evaluated each edge in priority order:
  1. Redirect (JalrSel|PCSel):
     - Target = JalrPC with bit0 cleared if JalrSel=1, else BrPC. JalrSel wins when both are asserted.
     - Flush=1 combinationally in the same cycle.
     - If target[1:0]!=0: MisalignErr<=1, IfId_Valid<=0, PC unchanged, next state HALT.
     - Otherwise: PC<=target[PC_W-1:0] (upper bits discarded), IfId_Valid<=0, IfId_Instr<=NOP, IfId_PC unchanged, RedirectCnt<=RedirectCnt+1 saturating at 2^CNT_W-1.
     - Redirect overrides Stall.
  2. Stall=1, no redirect: PC, IfId_PC, IfId_Instr, IfId_Valid all hold.
  3. Otherwise:
     - IfId_Instr<=Instr, IfId_PC<=PC, IfId_Valid<=1.
     - PC<=PC+4 modulo 2^PC_W; wraps from 2^PC_W-4 to 0 with no error.
- HALT:
  - PC, IfId_PC, IfId_Instr frozen; IfId_Valid=0; Flush=0; all inputs ignored.
  - Left only via reset.
- Flush is 0 outside RUN and is purely combinational from JalrSel|PCSel in RUN.
- Latency:
  - Instruction at PC appears in IF/ID one cycle later.
  - A redirect accepted at edge N yields the target instruction in IF/ID at edge N+1; exactly one bubble.
- No X propagation: BrPC and JalrPC are don't-care when their select is 0.

Test Plan:
- Reset then free-run with Instr=PC-derived pattern -> BOOT cycle with PC=0 and Valid=0; then IfId_PC=0,4,8... on successive cycles, Valid=1 from the 2nd post-BOOT edge, Instr matching.
- Stall=1 for 3 cycles at PC=0x10 -> PC=0x10, IfId_PC=0x0C held; sequencing resumes at 0x14 after release.
- PCSel=1, BrPC=0x40 at PC=0x18 with Stall=1 -> Flush=1, next PC=0x40, IfId_Valid=0, RedirectCnt=1; next edge IfId_PC=0x40, Valid=1.
- PCSel=1, BrPC=0x20, JalrSel=1, JalrPC=0x81 same cycle -> PC=0x80, RedirectCnt increments once.
- BrPC=0x22 taken -> MisalignErr=1, state HALT, PC frozen, Valid=0 despite further redirects; reset pulse clears MisalignErr and returns PC=0.
- PC=0x1FC with PC_W=9 -> next PC=0x000; then 256 redirects -> RedirectCnt saturates at 255.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch stage: program counter, instruction-memory address and IF/ID register.
// Branch and JALR redirects steer the next PC and squash the wrong-path fetch.
//
// state | meaning
// BOOT  | first cycle after reset, PC held at 0, nothing fetched
// RUN   | normal sequencing, stalls and redirects honoured
// HALT  | misaligned redirect seen, everything frozen until reset
module pc_fetch_unit #(
   parameter int PC_W  = 9,
   parameter int INS_W = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Stall,
   input  logic             PCSel,
   input  logic [31:0]      BrPC,
   input  logic             JalrSel,
   input  logic [31:0]      JalrPC,
   input  logic [INS_W-1:0] Instr,
   output logic [PC_W-1:0]  PC,
   output logic [PC_W-1:0]  IfId_PC,
   output logic [INS_W-1:0] IfId_Instr,
   output logic             IfId_Valid,
   output logic             Flush,
   output logic             MisalignErr,
   output logic [CNT_W-1:0] RedirectCnt
);

   localparam logic [INS_W-1:0] NOP = INS_W'(32'h0000_0013);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
   logic [INS_W-1:0]   ifid_instr_q, ifid_instr_d;
   logic               ifid_valid_q, ifid_valid_d;
   logic               misalign_q, misalign_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               flush;
   logic               redirect;
   logic [31:0]        target;
   logic               unused_target_hi;

   // JALR clears bit 0 of its target and wins over a simultaneous branch.
   assign redirect         = JalrSel | PCSel;
   assign target           = JalrSel ? (JalrPC & ~32'h1) : BrPC;
   assign unused_target_hi = ^target[31:PC_W];

   // Next-state and next-register computation; everything holds by default.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      misalign_d   = misalign_q;
      cnt_d        = cnt_q;
      flush        = 1'b0;
      case (state_q)
         ST_BOOT: begin
            ifid_valid_d = 1'b0;
            state_d      = ST_RUN;
         end
         ST_RUN: begin
            if (redirect) begin
               flush        = 1'b1;
               ifid_valid_d = 1'b0;
               if (target[1:0] != 2'b00) begin
                  misalign_d = 1'b1;
                  state_d    = ST_HALT;
               end else begin
                  pc_d         = target[PC_W-1:0];
                  ifid_instr_d = NOP;
                  cnt_d        = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
               end
            end else if (!Stall) begin
               ifid_instr_d = Instr;
               ifid_pc_d    = pc_q;
               ifid_valid_d = 1'b1;
               pc_d         = pc_q + PC_W'(4);
            end
         end
         ST_HALT: begin
            ifid_valid_d = 1'b0;
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   // State and pipeline registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_BOOT;
         pc_q         <= '0;
         ifid_pc_q    <= '0;
         ifid_instr_q <= NOP;
         ifid_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         misalign_q   <= misalign_d;
         cnt_q        <= cnt_d;
      end
   end

   assign PC          = pc_q;
   assign IfId_PC     = ifid_pc_q;
   assign IfId_Instr  = ifid_instr_q;
   assign IfId_Valid  = ifid_valid_q;
   assign Flush       = flush;
   assign MisalignErr = misalign_q;
   assign RedirectCnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural fetch model.
module tb_pc_fetch_unit;

   logic        clk;
   logic        reset;
   logic        Stall, PCSel, JalrSel;
   logic [31:0] BrPC, JalrPC, Instr;
   logic [8:0]  PC, IfId_PC;
   logic [31:0] IfId_Instr;
   logic        IfId_Valid, Flush, MisalignErr;
   logic [7:0]  RedirectCnt;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   // behavioural model
   int          m_pc, m_ifpc, m_cnt;
   logic [31:0] m_ifins;
   bit          m_valid, m_err, m_boot, m_halt;

   pc_fetch_unit #(.PC_W(9), .INS_W(32), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .Stall(Stall), .PCSel(PCSel), .BrPC(BrPC),
      .JalrSel(JalrSel), .JalrPC(JalrPC), .Instr(Instr), .PC(PC),
      .IfId_PC(IfId_PC), .IfId_Instr(IfId_Instr), .IfId_Valid(IfId_Valid),
      .Flush(Flush), .MisalignErr(MisalignErr), .RedirectCnt(RedirectCnt)
   );

   function automatic logic [31:0] imem(input logic [8:0] a);
      return {8'hA5, a, 6'h2A, a};
   endfunction

   assign Instr = imem(PC);

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_flush();
      return reset && !m_boot && !m_halt && (PCSel || JalrSel);
   endfunction

   task automatic model_reset();
      m_pc = 0; m_ifpc = 0; m_ifins = 32'h13; m_valid = 0;
      m_err = 0; m_cnt = 0; m_boot = 1; m_halt = 0;
   endtask

   task automatic model_edge();
      logic [31:0] t;
      if (!reset) model_reset();
      else if (m_boot) m_boot = 0;
      else if (m_halt) m_valid = 0;
      else if (PCSel || JalrSel) begin
         t = JalrSel ? (JalrPC & ~32'h1) : BrPC;
         m_valid = 0;
         if ((t & 32'h3) != 0) begin
            m_err  = 1;
            m_halt = 1;
         end else begin
            m_pc    = int'(t % 32'd512);
            m_ifins = 32'h13;
            m_cnt   = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
         end
      end else if (!Stall) begin
         m_ifins = imem(9'(m_pc));
         m_ifpc  = m_pc;
         m_valid = 1;
         m_pc    = (m_pc + 4) % 512;
      end
   endtask

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("pc",       32'(PC),          32'(m_pc));
            chk("ifid_pc",  32'(IfId_PC),     32'(m_ifpc));
            chk("ifid_ins", IfId_Instr,       m_ifins);
            chk("valid",    32'(IfId_Valid),  32'(m_valid));
            chk("flush",    32'(Flush),       32'(model_flush()));
            chk("misalign", 32'(MisalignErr), 32'(m_err));
            chk("cnt",      32'(RedirectCnt), 32'(m_cnt));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      Stall = 0; PCSel = 0; JalrSel = 0; BrPC = 0; JalrPC = 0;
   endtask

   // Reset for two edges, released just after an edge; BOOT edge is next.
   task automatic do_reset();
      reset = 0;
      model_reset();
      step();
      step();
      reset = 1;
   endtask

   initial begin
      int rst_hold;
      idle_inputs();
      reset = 1;
      model_reset();
      #2;
      reset = 0;
      chk_en = 1;
      step();
      step();
      reset = 1;

      // boot and free run
      chk("boot_pc", 32'(PC), 32'h0);
      chk("boot_valid", 32'(IfId_Valid), 32'h0);
      step();
      chk("post_boot_pc", 32'(PC), 32'h0);
      chk("post_boot_valid", 32'(IfId_Valid), 32'h0);
      step();
      chk("first_ifpc", 32'(IfId_PC), 32'h0);
      chk("first_valid", 32'(IfId_Valid), 32'h1);
      chk("first_instr", IfId_Instr, 32'hA500_5400);
      step();
      chk("second_ifpc", 32'(IfId_PC), 32'h4);
      step();
      step();
      chk("pre_stall_pc", 32'(PC), 32'h10);

      // stall three cycles
      Stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", 32'(PC), 32'h10);
         chk("stall_ifpc", 32'(IfId_PC), 32'h0C);
      end
      Stall = 0;
      step();
      chk("resume_ifpc", 32'(IfId_PC), 32'h10);
      chk("resume_pc", 32'(PC), 32'h14);
      step();
      chk("pre_br_pc", 32'(PC), 32'h18);

      // branch overriding stall
      Stall = 1; PCSel = 1; BrPC = 32'h40;
      #1;
      chk("br_flush", 32'(Flush), 32'h1);
      step();
      chk("br_pc", 32'(PC), 32'h40);
      chk("br_valid", 32'(IfId_Valid), 32'h0);
      chk("br_cnt", 32'(RedirectCnt), 32'h1);
      idle_inputs();
      step();
      chk("br_target_ifpc", 32'(IfId_PC), 32'h40);
      chk("br_target_valid", 32'(IfId_Valid), 32'h1);

      // JALR wins over branch
      PCSel = 1; BrPC = 32'h20; JalrSel = 1; JalrPC = 32'h81;
      step();
      chk("jalr_pc", 32'(PC), 32'h80);
      chk("jalr_cnt", 32'(RedirectCnt), 32'h2);
      idle_inputs();
      step();

      // wrap at top of address space
      PCSel = 1; BrPC = 32'hFFFF_F1FC;
      step();
      chk("wrap_setup_pc", 32'(PC), 32'h1FC);
      idle_inputs();
      step();
      chk("wrap_pc", 32'(PC), 32'h0);
      chk("wrap_ifpc", 32'(IfId_PC), 32'h1FC);

      // randomized traffic with occasional asynchronous resets
      rst_hold = 0;
      for (int i = 0; i < 500; i++) begin
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) reset = 1;
         end
         Stall   = ($urandom % 4) == 0;
         PCSel   = ($urandom % 8) == 0;
         JalrSel = ($urandom % 16) == 0;
         BrPC    = $urandom;
         BrPC[1:0] = (($urandom % 12) == 0) ? 2'($urandom) : 2'b00;
         JalrPC  = $urandom;
         JalrPC[1] = (($urandom % 12) == 0);
         if (rst_hold == 0 && ($urandom % 40) == 0) begin
            #2;
            reset = 0;
            model_reset();
            rst_hold = 2;
         end
         step();
      end
      idle_inputs();
      do_reset();
      step();
      step();

      // misaligned target halts
      PCSel = 1; BrPC = 32'h22;
      #1;
      chk("mis_flush", 32'(Flush), 32'h1);
      step();
      chk("mis_err", 32'(MisalignErr), 32'h1);
      chk("mis_valid", 32'(IfId_Valid), 32'h0);
      chk("mis_pc", 32'(PC), 32'h4);
      BrPC = 32'h40;
      #1;
      chk("halt_flush", 32'(Flush), 32'h0);
      step();
      step();
      chk("halt_pc", 32'(PC), 32'h4);
      chk("halt_valid", 32'(IfId_Valid), 32'h0);
      idle_inputs();
      #2;
      reset = 0;
      model_reset();
      #1;
      chk("async_rst_err", 32'(MisalignErr), 32'h0);
      chk("async_rst_pc", 32'(PC), 32'h0);
      step();
      reset = 1;
      step();

      // counter saturation
      PCSel = 1;
      for (int i = 0; i < 260; i++) begin
         BrPC = $urandom & 32'h1FC;
         step();
      end
      chk("cnt_sat", 32'(RedirectCnt), 32'hFF);
      idle_inputs();
      step();
      step();

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
